// File: rtl/bbs_gen.sv
// Blum-Blum-Shub random word generator: serial p*q, bit-serial modular squaring.
// Build option BBS_PARITY_EN: each output bit is the parity of x instead of its LSB.

module bbs_gen #(
    parameter int N      = 32,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              keep_m,
    input  logic              stop,
    input  logic [N-1:0]      p,
    input  logic [N-1:0]      q,
    input  logic [N-1:0]      seed,
    output logic [2*N-1:0]    m,
    output logic              m_valid,
    output logic              err,
    output logic              busy,
    output logic [WORD_W-1:0] rnd_word,
    output logic              rnd_valid,
    input  logic              rnd_ready
);

    localparam int MW = 2 * N;
    localparam int CW = $clog2(MW);
    localparam int BW = $clog2(WORD_W + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CALC_M  = 3'd1;
    localparam logic [2:0] SEED_SQ = 3'd2;
    localparam logic [2:0] GEN     = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    logic [2:0]        state;
    logic [N-1:0]      op_p;
    logic [N-1:0]      op_q;
    logic [MW-1:0]     x;
    logic [MW-1:0]     acc;
    logic [MW-1:0]     red;
    logic [CW-1:0]     step;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-1:0] sr;

    logic [MW-1:0]     mul_next;
    logic [CW-1:0]     bit_idx;
    logic [CW-1:0]     red_idx;
    logic [MW:0]       m_ext;
    logic [MW:0]       dbl;
    logic [MW:0]       sum;
    logic [MW:0]       red2;
    logic [MW-1:0]     dbl_r;
    logic [MW-1:0]     sum_r;
    logic [MW-1:0]     addend;
    logic [MW-1:0]     acc_next;
    logic [MW-1:0]     red_next;
    logic              out_bit;
    logic              sq_done;
    logic              word_done;
    logic              can_load;
    logic [WORD_W-1:0] sr_next;

    assign busy = (state != IDLE);

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        mul_next = {m[MW-2:0], 1'b0} + (op_q[N-1] ? MW'(op_p) : '0);
        bit_idx  = CW'(MW - 1) - step;
        red_idx  = bit_idx - CW'(N);
        m_ext    = {1'b0, m};
        // While squaring the seed, its upper N scan bits are zero, so those cycles
        // reduce seed mod M into red, which becomes the addend for the lower N bits.
        addend   = (state == SEED_SQ) ? red : x;
        dbl      = {acc, 1'b0};
        dbl_r    = MW'((dbl >= m_ext) ? dbl - m_ext : dbl);
        sum      = {1'b0, dbl_r} + {1'b0, addend};
        sum_r    = MW'((sum >= m_ext) ? sum - m_ext : sum);
        acc_next = x[bit_idx] ? sum_r : dbl_r;
        red2     = {red, x[red_idx]};
        red_next = MW'((red2 >= m_ext) ? red2 - m_ext : red2);
`ifdef BBS_PARITY_EN
        out_bit  = ^acc_next;
`else
        out_bit  = acc_next[0];
`endif
        sr_next              = sr >> 1;
        sr_next[WORD_W-1]    = out_bit;
        sq_done   = (step == CW'(MW - 1));
        word_done = sq_done && (bit_cnt == BW'(WORD_W - 1));
        can_load  = !rnd_valid || rnd_ready;
    end

    // NOTE: sequential state uses non-blocking assignments only; a later assignment in
    // the same block overrides the default drop of rnd_valid when a new word loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_p      <= '0;
            op_q      <= '0;
            x         <= '0;
            acc       <= '0;
            red       <= '0;
            step      <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            m         <= '0;
            m_valid   <= 1'b0;
            err       <= 1'b0;
            rnd_word  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            if (rnd_valid && rnd_ready) rnd_valid <= 1'b0;

            if (stop && state != IDLE) begin
                state   <= IDLE;
                step    <= '0;
                bit_cnt <= '0;
                acc     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            step    <= '0;
                            acc     <= '0;
                            bit_cnt <= '0;
                            if (!keep_m || !m_valid) begin
                                op_p    <= p;
                                op_q    <= q;
                                x       <= MW'(seed);
                                m       <= '0;
                                m_valid <= 1'b0;
                                err     <= 1'b0;
                                state   <= CALC_M;
                            end else begin
                                state   <= GEN;
                            end
                        end
                    end
                    CALC_M: begin
                        m    <= mul_next;
                        op_q <= op_q << 1;
                        step <= step + 1'b1;
                        if (step == CW'(N - 1)) begin
                            step <= '0;
                            acc  <= '0;
                            red  <= '0;
                            if (mul_next < MW'(2)) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                m_valid <= 1'b1;
                                state   <= SEED_SQ;
                            end
                        end
                    end
                    SEED_SQ: begin
                        acc  <= acc_next;
                        step <= step + 1'b1;
                        if (step < CW'(N)) red <= red_next;
                        if (sq_done) begin
                            x       <= acc_next;
                            acc     <= '0;
                            step    <= '0;
                            bit_cnt <= '0;
                            state   <= GEN;
                        end
                    end
                    GEN: begin
                        acc  <= acc_next;
                        step <= step + 1'b1;
                        if (sq_done) begin
                            x    <= acc_next;
                            acc  <= '0;
                            step <= '0;
                            sr   <= sr_next;
                            if (word_done) begin
                                bit_cnt <= '0;
                                if (can_load) begin
                                    rnd_word  <= sr_next;
                                    rnd_valid <= 1'b1;
                                end else begin
                                    state <= HOLD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (rnd_ready) begin
                            rnd_word  <= sr;
                            rnd_valid <= 1'b1;
                            state     <= GEN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bbs_gen.sv
// Self-checking bench for bbs_gen: vector table, directed corner sequences and a
// randomized run scored against an arithmetic BBS model (x*x mod M).

module tb_bbs_gen;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int ND = 32;
    localparam int WD = 32;

`ifdef BBS_PARITY_EN
    localparam logic [7:0] REF_WORD = 8'h4B;
`else
    localparam logic [7:0] REF_WORD = 8'h29;
`endif

    typedef logic [127:0] big_t;

    typedef struct {
        logic [N-1:0]   p;
        logic [N-1:0]   q;
        logic [N-1:0]   seed;
        logic [2*N-1:0] exp_m;
        logic           exp_err;
        logic [W-1:0]   exp_word;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, keep_m, stop, rnd_ready;
    logic [N-1:0]   p, q, seed;
    logic [2*N-1:0] m;
    logic           m_valid, err, busy, rnd_valid;
    logic [W-1:0]   rnd_word;

    logic            rst_d, start_d, keep_m_d, stop_d, rnd_ready_d;
    logic [ND-1:0]   p_d, q_d, seed_d;
    logic [2*ND-1:0] m_d;
    logic            m_valid_d, err_d, busy_d, rnd_valid_d;
    logic [WD-1:0]   rnd_word_d;

    int n_tests = 0;
    int n_fail  = 0;

    bbs_gen #(.N(N), .WORD_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_m(keep_m), .stop(stop),
        .p(p), .q(q), .seed(seed), .m(m), .m_valid(m_valid), .err(err), .busy(busy),
        .rnd_word(rnd_word), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready)
    );

    bbs_gen #(.N(ND), .WORD_W(WD)) dut_d (
        .clk(clk), .rst(rst_d), .start(start_d), .keep_m(keep_m_d), .stop(stop_d),
        .p(p_d), .q(q_d), .seed(seed_d), .m(m_d), .m_valid(m_valid_d), .err(err_d),
        .busy(busy_d), .rnd_word(rnd_word_d), .rnd_valid(rnd_valid_d),
        .rnd_ready(rnd_ready_d)
    );

    task automatic check(input string name, input big_t act, input big_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic big_t sq_mod(input big_t xv, input big_t mm);
        big_t t;
        t = xv * xv;
        return t % mm;
    endfunction

    function automatic logic ext_bit(input big_t v);
`ifdef BBS_PARITY_EN
        return ^v;
`else
        return v[0];
`endif
    endfunction

    // Next output word: WORD_W squarings, first extracted bit lands in bit 0.
    task automatic model_word(input big_t mm, input big_t xin, input int w,
                              output big_t xout, output big_t word);
        big_t xs;
        xs   = xin;
        word = '0;
        for (int i = 0; i < w; i++) begin
            xs      = sq_mod(xs, mm);
            word[i] = ext_bit(xs);
        end
        xout = xs;
    endtask

    task automatic start_gen(input logic [N-1:0] pp, input logic [N-1:0] qq,
                             input logic [N-1:0] ss, input logic km);
        p = pp; q = qq; seed = ss; keep_m = km; start = 1'b1;
        @(negedge clk);
        start = 1'b0; keep_m = 1'b0;
    endtask

    task automatic wait_valid(input int budget, inout int lat);
        int k;
        k = 0;
        while (!rnd_valid && k < budget) begin
            @(negedge clk);
            lat++;
            k++;
        end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        rnd_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        big_t mm, xs, w1, w2, w3, wexp;
        int   lat;

        rst = 1'b1; start = 0; keep_m = 0; stop = 0; rnd_ready = 1'b1;
        p = '0; q = '0; seed = '0;
        rst_d = 1'b1; start_d = 0; keep_m_d = 0; stop_d = 0; rnd_ready_d = 1'b1;
        p_d = '0; q_d = '0; seed_d = '0;

        repeat (2) @(negedge clk);
        check("reset m", m, 0);
        check("reset m_valid", m_valid, 0);
        check("reset err", err, 0);
        check("reset busy", busy, 0);
        check("reset rnd_valid", rnd_valid, 0);
        check("reset rnd_word", rnd_word, 0);
        rst = 1'b0; rst_d = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 0);

        // ---------------- vector table ----------------
        vecs[0] = '{p: 8'd11, q: 8'd23, seed: 8'd3, exp_m: 16'd253, exp_err: 1'b0,
                    exp_word: REF_WORD};
        vecs[1] = '{p: 8'd1,  q: 8'd1,   seed: 8'd7, exp_m: 16'd1, exp_err: 1'b1, exp_word: 8'd0};
        vecs[2] = '{p: 8'd0,  q: 8'd200, seed: 8'd5, exp_m: 16'd0, exp_err: 1'b1, exp_word: 8'd0};
        vecs[3] = '{p: 8'd13, q: 8'd17,  seed: 8'd200, exp_m: 16'd0, exp_err: 1'b0, exp_word: 8'd0};
        vecs[4] = '{p: 8'd2,  q: 8'd3,   seed: 8'd250, exp_m: 16'd0, exp_err: 1'b0, exp_word: 8'd0};
        vecs[5] = '{p: 8'd255, q: 8'd255, seed: 8'd254, exp_m: 16'd0, exp_err: 1'b0, exp_word: 8'd0};
        for (int i = 3; i < 6; i++) begin
            mm = big_t'(vecs[i].p) * big_t'(vecs[i].q);
            vecs[i].exp_m = mm[2*N-1:0];
            xs = sq_mod(big_t'(vecs[i].seed), mm);
            model_word(mm, xs, W, xs, wexp);
            vecs[i].exp_word = wexp[W-1:0];
        end

        for (int i = 0; i < 6; i++) begin
            rnd_ready = 1'b1;
            start_gen(vecs[i].p, vecs[i].q, vecs[i].seed, 1'b0);
            lat = 0;
            repeat (8) begin @(negedge clk); lat++; end
            check($sformatf("row%0d err", i), err, vecs[i].exp_err);
            check($sformatf("row%0d m_valid", i), m_valid, !vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                check($sformatf("row%0d busy after err", i), busy, 0);
            end else begin
                check($sformatf("row%0d m", i), m, vecs[i].exp_m);
                wait_valid(300, lat);
                check($sformatf("row%0d word arrived", i), rnd_valid, 1);
                check($sformatf("row%0d latency", i), lat, 152);
                check($sformatf("row%0d word", i), rnd_word, vecs[i].exp_word);
                do_stop();
            end
        end

        // ---------------- randomized run with random back-pressure ----------------
        for (int it = 0; it < 2; it++) begin
            logic [N-1:0] rp, rq, rs;
            logic         prev_stall;
            logic [W-1:0] prev_word;
            int           got, cyc;
            rp = N'($urandom_range(2, 255));
            rq = N'($urandom_range(2, 255));
            rs = N'($urandom_range(0, 255));
            mm = big_t'(rp) * big_t'(rq);
            xs = sq_mod(big_t'(rs), mm);
            rnd_ready = 1'b1;
            start_gen(rp, rq, rs, 1'b0);
            got = 0; cyc = 0; prev_stall = 1'b0; prev_word = '0;
            while (got < 4 && cyc < 4000) begin
                if (prev_stall) begin
                    check("rand stall valid", rnd_valid, 1);
                    check("rand stall word", rnd_word, prev_word);
                end
                rnd_ready = ($urandom_range(0, 1) == 1);
                if (rnd_valid && rnd_ready) begin
                    model_word(mm, xs, W, xs, wexp);
                    check($sformatf("rand it%0d word%0d", it, got), rnd_word, wexp[W-1:0]);
                    got++;
                end
                prev_stall = rnd_valid && !rnd_ready;
                prev_word  = rnd_word;
                @(negedge clk);
                cyc++;
            end
            check("rand words received", got, 4);
            do_stop();
        end

        // ---------------- reference words for p=11, q=23, seed=3 ----------------
        mm = 253;
        xs = sq_mod(3, mm);
        model_word(mm, xs, W, xs, w1);
        model_word(mm, xs, W, xs, w2);
        check("model first word", w1, REF_WORD);

        // ---------------- err, then keep_m must recompute M ----------------
        start_gen(8'd1, 8'd1, 8'd9, 1'b0);
        repeat (8) @(negedge clk);
        check("err set", err, 1);
        check("err m_valid", m_valid, 0);
        check("err busy", busy, 0);
        start_gen(8'd11, 8'd23, 8'd3, 1'b1);
        check("err cleared on start", err, 0);
        check("keep_m after err busy", busy, 1);
        repeat (8) @(negedge clk);
        check("recompute m_valid", m_valid, 1);
        check("recompute m", m, 253);
        do_stop();

        // ---------------- back-pressure: HOLD ----------------
        rnd_ready = 1'b0;
        start_gen(8'd11, 8'd23, 8'd3, 1'b0);
        lat = 0;
        wait_valid(300, lat);
        check("hold first latency", lat, 152);
        check("hold first word", rnd_word, REF_WORD);
        repeat (248) @(negedge clk);
        check("hold word stable", rnd_word, REF_WORD);
        check("hold valid", rnd_valid, 1);
        check("hold busy", busy, 1);
        rnd_ready = 1'b1;
        @(negedge clk);
        check("hold second word", rnd_word, w2);
        check("hold second valid", rnd_valid, 1);
        @(negedge clk);
        check("valid drops after transfer", rnd_valid, 0);
        do_stop();

        // ---------------- stop at word boundary, resume with keep_m ----------------
        rnd_ready = 1'b1;
        start_gen(8'd11, 8'd23, 8'd3, 1'b0);
        lat = 0;
        wait_valid(300, lat);
        check("resume first word", rnd_word, REF_WORD);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop busy", busy, 0);
        check("stop keeps m_valid", m_valid, 1);
        start_gen(8'd0, 8'd0, 8'd0, 1'b1);
        lat = 0;
        repeat (20) begin @(negedge clk); lat++; end
        start_gen(8'd3, 8'd5, 8'd7, 1'b0);
        lat++;
        wait_valid(300, lat);
        check("resume latency", lat, 128);
        check("resume word", rnd_word, w2);
        check("busy start ignored m", m, 253);
        do_stop();

        // ---------------- asynchronous reset mid-GEN ----------------
        rnd_ready = 1'b0;
        start_gen(8'd11, 8'd23, 8'd3, 1'b0);
        repeat (160) @(negedge clk);
        check("pre-reset valid", rnd_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst m", m, 0);
        check("async rst m_valid", m_valid, 0);
        check("async rst err", err, 0);
        check("async rst busy", busy, 0);
        check("async rst rnd_word", rnd_word, 0);
        check("async rst rnd_valid", rnd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        rnd_ready = 1'b1;
        start_gen(8'd11, 8'd23, 8'd3, 1'b1);
        check("post-rst keep_m recompute m_valid", m_valid, 0);
        lat = 0;
        wait_valid(300, lat);
        check("post-rst latency", lat, 152);
        check("post-rst word", rnd_word, REF_WORD);
        do_stop();

        // ---------------- default parameters ----------------
        mm = 64'd1353128073;
        xs = sq_mod(56686, mm);
        model_word(mm, xs, WD, xs, w1);
        model_word(mm, xs, WD, xs, w2);
        model_word(mm, xs, WD, xs, w3);
        p_d = 32'd29711; q_d = 32'd45543; seed_d = 32'd56686; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        lat = 0;
        repeat (32) begin @(negedge clk); lat++; end
        check("dflt m", m_d, 64'd1353128073);
        check("dflt m_valid", m_valid_d, 1);
        while (!rnd_valid_d && lat < 3000) begin @(negedge clk); lat++; end
        check("dflt first latency", lat, 2144);
        check("dflt word1", rnd_word_d, w1[WD-1:0]);
        @(negedge clk);
        lat = 1;
        while (!rnd_valid_d && lat < 3000) begin @(negedge clk); lat++; end
        check("dflt word2 interval", lat, 2048);
        check("dflt word2", rnd_word_d, w2[WD-1:0]);
        stop_d = 1'b1;
        @(negedge clk);
        stop_d = 1'b0;
        check("dflt stop busy", busy_d, 0);
        keep_m_d = 1'b1; start_d = 1'b1;
        @(negedge clk);
        keep_m_d = 1'b0; start_d = 1'b0;
        lat = 0;
        while (!rnd_valid_d && lat < 3000) begin @(negedge clk); lat++; end
        check("dflt resume latency", lat, 2048);
        check("dflt resume word", rnd_word_d, w3[WD-1:0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
